fp_unit_arbiter: RTL and testbench
==================================

# fp_unit_arbiter

Shares one pipelined floating-point arithmetic unit between up to NUM_REQ requesters, such as the Kalman filter rate, angle and covariance stages. The unit is the ADD, SUB and MULT cores selected by an op code, with a fixed latency of LAT cycles. The arbiter grants one operation per cycle in round-robin order and drives the unit's operands. It tracks every in-flight operation with a tag pipeline and returns each result to the requester that issued it. It sits between the filter stage logic and the FP IP cores.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- LAT, 7: FP core latency in cycles, from operands presented to q valid; same for all ops, 1..16.
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high; also drives the FP cores' areset.
- issue_en  in  1  when low, no new grants; in-flight operations drain normally.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_op  in  2*NUM_REQ  per requester: 00 add, 01 sub (a-b), 10 mul, 11 illegal.
- req_a, req_b  in  32*NUM_REQ  per-requester IEEE-754 single operands.
- req_ready  out  NUM_REQ  combinational grant; accept = req_valid[i] & req_ready[i].
- fpu_issue  out  1  operands on fpu_a/fpu_b are valid this cycle.
- fpu_op  out  2  op for the issued operands.
- fpu_a, fpu_b  out  32  registered operands to the FP cores.
- fpu_q  in  32  FP core result, valid LAT cycles after the matching fpu_issue.
- rsp_valid  out  NUM_REQ  one-cycle, one-hot result strobe to the owning requester.
- rsp_data  out  32  registered result; valid only while some rsp_valid bit is high.
- inflight  out  5  count of accepted operations whose rsp_valid has not yet fired.
- idle  out  1  inflight==0.
- illegal_op  out  1  sticky; set when an op 11 request is accepted; cleared only by reset.

## Operation
- Round-robin pointer ptr, reset 0.
  - Each cycle with issue_en=1, grant the first i with req_valid[i]=1, searching ptr, ptr+1, … mod NUM_REQ.
  - At most one req_ready bit is high. req_ready is all-zero when issue_en=0 or no request is pending.
- On acceptance of requester i:
  - ptr <= (i+1) mod NUM_REQ.
  - Register fpu_a, fpu_b and fpu_op from requester i, and set fpu_issue=1 next cycle.
  - Push tag {valid=1, id=i} into a LAT-deep shift register that advances every cycle.
- When no request is accepted, fpu_issue=0 next cycle and a tag with valid=0 is pushed. fpu_a, fpu_b and fpu_op hold their previous values.
- Illegal op (11): the request is accepted and ptr advances. No fpu_issue and no tag are produced, inflight is not incremented, and illegal_op is set.
- When the tag leaves the shift register with valid=1, the tag output coincides with fpu_q being valid. On the next edge, rsp_data <= fpu_q and rsp_valid <= onehot(id).
- inflight:
  - +1 on a legal acceptance; -1 on a rsp_valid cycle; both in the same cycle leaves it unchanged.
  - Maximum value is LAT+2, so no overflow is possible.
- Requesters cannot stall responses. A requester may have any number of operations in flight. Its results return in its own issue order, because latency is fixed.
- Reset values, asynchronous:
  - All tags invalid; ptr=0; inflight=0.
  - fpu_issue=0, fpu_op=0, fpu_a=0, fpu_b=0.
  - rsp_valid=0, rsp_data=0, illegal_op=0; idle=1.
  - No rsp_valid may fire after reset for operations accepted before reset.

## Timing
- Accept at edge t: fpu_issue high in cycle t+1, and fpu_q is valid in cycle t+1+LAT.
- rsp_valid is high for exactly one cycle, t+2+LAT. Acceptance to response latency is therefore LAT+2.
- Throughput is one operation per cycle sustained. Back-to-back grants produce back-to-back rsp_valid pulses in grant order.
- Deassertion of issue_en takes effect in the same cycle, because req_ready is combinational.
- A request held valid by a requester is granted within NUM_REQ cycles while issue_en=1.
- Simultaneous events:
  - Acceptance and response in the same cycle are independent.
  - The response may target the requester being granted.
- Reset asserted mid-operation clears everything immediately. Outputs hold reset values until the first edge after reset deasserts.

## Test plan
- Single add, LAT=7: requester 0 issues 0x3F800000 + 0x40000000 at edge t. Required: fpu_issue at t+1; rsp_valid=0001 with rsp_data=0x40400000 at t+9; inflight goes 1 then 0; idle returns to 1.
- All four requesters valid continuously, each issuing 2.0*3.0. Required: grants in order 0,1,2,3,0,…; each rsp_data=0x40C00000; rsp_valid rotates one-hot in the same order with no gaps.
- Requester 2 only, 10 consecutive subs (k.0 - 1.0, k=1..10). Required: 10 consecutive rsp_valid pulses to requester 2, results 0.0…9.0 in order.
- issue_en dropped after 3 grants with 2 further requests pending. Required: no further req_ready; the 3 responses still return; idle=1 at LAT+2 cycles after the last grant.
- Requester 1 issues op 11. Required: req_ready[1]=1; no fpu_issue; illegal_op=1 and remains set; inflight unchanged.
- Reset asserted 3 cycles after 5 back-to-back grants. Required: no rsp_valid ever fires for those grants; inflight=0, ptr=0, illegal_op=0; the next grant goes to the lowest-index valid requester.

Source files
------------

// File: rtl/fp_unit_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FP add/sub/mul unit between NUM_REQ requesters.
// Accept-to-response latency LAT+2; requesters cannot stall responses, a grant is withheld only by issue_en.
module fp_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LAT     = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    issue_en,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [2*NUM_REQ-1:0]    req_op,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    fpu_issue,
  output logic [1:0]              fpu_op,
  output logic [31:0]             fpu_a,
  output logic [31:0]             fpu_b,
  input  logic [31:0]             fpu_q,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [31:0]             rsp_data,
  output logic [4:0]              inflight,
  output logic                    idle,
  output logic                    illegal_op
);

  localparam int PW = $clog2(NUM_REQ);
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  logic [PW-1:0]      ptr_q;
  logic               gnt_vld;
  logic [PW-1:0]      gnt_id;
  logic [1:0]         gnt_op;
  logic [31:0]        gnt_a;
  logic [31:0]        gnt_b;
  logic               gnt_legal;

  logic               fpu_issue_q;
  logic [1:0]         fpu_op_q;
  logic [31:0]        fpu_a_q;
  logic [31:0]        fpu_b_q;

  // Stage 0 is aligned with fpu_issue; stage LAT is aligned with fpu_q.
  logic [LAT:0]       tag_vld_q;
  logic [PW-1:0]      tag_id_q [0:LAT];

  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [31:0]        rsp_data_q;
  logic [4:0]         inflight_q;
  logic [4:0]         inflight_d;
  logic               illegal_q;

  always_comb begin
    logic [PW-1:0] idx;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PW'((int'(ptr_q) + k) % NUM_REQ);
      if (issue_en && !gnt_vld && req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  assign req_ready = gnt_vld ? (NUM_REQ'(1) << gnt_id) : '0;
  assign gnt_op    = req_op[int'(gnt_id)*2 +: 2];
  assign gnt_a     = req_a[int'(gnt_id)*32 +: 32];
  assign gnt_b     = req_b[int'(gnt_id)*32 +: 32];
  assign gnt_legal = gnt_vld && (gnt_op != OP_ILLEGAL);

  assign inflight_d = inflight_q + 5'(gnt_legal) - 5'(|rsp_valid_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q       <= '0;
      fpu_issue_q <= 1'b0;
      fpu_op_q    <= 2'b00;
      fpu_a_q     <= '0;
      fpu_b_q     <= '0;
      tag_vld_q   <= '0;
      for (int s = 0; s <= LAT; s++) tag_id_q[s] <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      inflight_q  <= '0;
      illegal_q   <= 1'b0;
    end else begin
      if (gnt_vld) begin
        ptr_q <= (gnt_id == PW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
      end
      fpu_issue_q <= gnt_legal;
      if (gnt_legal) begin
        fpu_op_q <= gnt_op;
        fpu_a_q  <= gnt_a;
        fpu_b_q  <= gnt_b;
      end
      tag_vld_q[0] <= gnt_legal;
      tag_id_q[0]  <= gnt_id;
      for (int s = 1; s <= LAT; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
      end
      rsp_valid_q <= tag_vld_q[LAT] ? (NUM_REQ'(1) << tag_id_q[LAT]) : '0;
      if (tag_vld_q[LAT]) rsp_data_q <= fpu_q;
      inflight_q <= inflight_d;
      if (gnt_vld && (gnt_op == OP_ILLEGAL)) illegal_q <= 1'b1;
    end
  end

  assign fpu_issue  = fpu_issue_q;
  assign fpu_op     = fpu_op_q;
  assign fpu_a      = fpu_a_q;
  assign fpu_b      = fpu_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign inflight   = inflight_q;
  assign idle       = (inflight_q == 5'd0);
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Randomized and directed bench for fp_unit_arbiter with a behavioural FP core and a due-cycle scoreboard.
module tb_fp_unit_arbiter;
  localparam int NUM_REQ = 4;
  localparam int LAT     = 7;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  issue_en = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [2*NUM_REQ-1:0]  req_op = '0;
  logic [32*NUM_REQ-1:0] req_a = '0;
  logic [32*NUM_REQ-1:0] req_b = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  fpu_issue;
  logic [1:0]            fpu_op;
  logic [31:0]           fpu_a, fpu_b, fpu_q;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [31:0]           rsp_data;
  logic [4:0]            inflight;
  logic                  idle, illegal_op;

  fp_unit_arbiter #(.NUM_REQ(NUM_REQ), .LAT(LAT)) dut (
    .clk(clk), .reset(rst), .issue_en(issue_en),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .fpu_issue(fpu_issue), .fpu_op(fpu_op),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_q(fpu_q),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .inflight(inflight),
    .idle(idle), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic real sp2r(input logic [31:0] x);
    real r;
    if (x[30:0] == 31'd0) return 0.0;
    r = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** real'(int'(x[30:23]) - 127));
    return x[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2sp(input real v);
    real a;
    int e;
    logic [22:0] m;
    if (v == 0.0) return 32'h0;
    a = (v < 0.0) ? -v : v;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    m = 23'($rtoi((a - 1.0) * 8388608.0));
    return {(v < 0.0), 8'(e), m};
  endfunction

  function automatic logic [31:0] fp_ref(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    case (op)
      2'd0:    return r2sp(sp2r(a) + sp2r(b));
      2'd1:    return r2sp(sp2r(a) - sp2r(b));
      2'd2:    return r2sp(sp2r(a) * sp2r(b));
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  // Behavioural FP core: result appears LAT cycles after the operands.
  logic [31:0] core_pipe [LAT];
  always @(posedge clk) begin
    for (int s = LAT - 1; s > 0; s--) core_pipe[s] <= core_pipe[s-1];
    core_pipe[0] <= fpu_issue ? fp_ref(fpu_a, fpu_b, fpu_op) : 32'hDEADBEEF;
  end
  assign fpu_q = core_pipe[LAT-1];

  typedef struct { int due; int id; logic [31:0] dat; } rsp_t;
  rsp_t        sb[$];
  int          cyc = 0;
  int          mptr = 0;
  int          minf = 0;
  logic        mill = 1'b0;
  logic        prev_legal = 1'b0;
  logic [1:0]  prev_op;
  logic [31:0] prev_a, prev_b;
  logic [31:0] tb_exp [NUM_REQ];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    req_op[i*2 +: 2]  = op;
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    tb_exp[i]         = exp;
  endtask

  task automatic step();
    int g;
    bit fired;
    logic [1:0] op;
    logic [NUM_REQ-1:0] exp_rdy, exp_rsp;
    @(negedge clk);
    g = -1;
    if (issue_en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int idx = (mptr + k) % NUM_REQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    exp_rdy = (g >= 0) ? (NUM_REQ'(1) << g) : '0;
    fired   = (sb.size() > 0) && (sb[0].due == cyc);
    exp_rsp = fired ? (NUM_REQ'(1) << sb[0].id) : '0;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
    if (fired) check("rsp_data", rsp_data, sb[0].dat);
    check("fpu_issue", 32'(fpu_issue), 32'(prev_legal));
    if (prev_legal) begin
      check("fpu_op", 32'(fpu_op), 32'(prev_op));
      check("fpu_a", fpu_a, prev_a);
      check("fpu_b", fpu_b, prev_b);
    end
    check("inflight", 32'(inflight), minf);
    check("idle", 32'(idle), 32'(minf == 0));
    check("illegal_op", 32'(illegal_op), 32'(mill));
    prev_legal = 1'b0;
    if (g >= 0) begin
      op   = req_op[g*2 +: 2];
      mptr = (g + 1) % NUM_REQ;
      if (op == 2'b11) mill = 1'b1;
      else begin
        sb.push_back('{cyc + LAT + 2, g, tb_exp[g]});
        minf++;
        prev_legal = 1'b1;
        prev_op = op;
        prev_a  = req_a[g*32 +: 32];
        prev_b  = req_b[g*32 +: 32];
      end
    end
    if (fired) begin
      void'(sb.pop_front());
      minf--;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_inflight", 32'(inflight), 0);
      check("rst_idle", 32'(idle), 1);
      check("rst_illegal", 32'(illegal_op), 0);
      check("rst_fpu_issue", 32'(fpu_issue), 0);
      check("rst_fpu_op", 32'(fpu_op), 0);
      check("rst_fpu_a", fpu_a, 0);
      check("rst_fpu_b", fpu_b, 0);
      @(posedge clk);
      cyc++;
      #1;
    end
    rst = 1'b0;
    sb.delete();
    mptr = 0;
    minf = 0;
    mill = 1'b0;
    prev_legal = 1'b0;
  endtask

  task automatic drain(input int n);
    req_valid = '0;
    repeat (n) step();
  endtask

  function automatic logic [31:0] rnd_fp();
    return r2sp(real'(int'($urandom_range(40)) - 20));
  endfunction

  initial begin
    @(posedge clk);
    #1;
    apply_reset();
    issue_en = 1'b1;

    // Single add 1.0 + 2.0
    set_req(0, 2'd0, 32'h3F800000, 32'h40000000, 32'h40400000);
    req_valid = 4'b0001;
    step();
    drain(LAT + 4);

    // All requesters 2.0 * 3.0 continuously
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 2'd2, 32'h40000000, 32'h40400000, 32'h40C00000);
    req_valid = 4'b1111;
    repeat (9) step();
    drain(LAT + 4);

    // Requester 2 only: k - 1.0
    for (int k = 1; k <= 10; k++) begin
      set_req(2, 2'd1, r2sp(real'(k)), 32'h3F800000, r2sp(real'(k - 1)));
      req_valid = 4'b0100;
      step();
    end
    drain(LAT + 4);

    // issue_en dropped after 3 grants with requests still pending
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 2'd0, 32'h3F800000, 32'h3F800000, 32'h40000000);
    req_valid = 4'b1111;
    repeat (3) step();
    issue_en = 1'b0;
    repeat (LAT + 4) step();
    req_valid = '0;
    issue_en = 1'b1;

    // Illegal op from requester 1
    set_req(1, 2'b11, 32'h3F800000, 32'h3F800000, 32'h0);
    req_valid = 4'b0010;
    step();
    drain(4);

    // Reset mid-flight after 5 back-to-back grants
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 2'd0, 32'h40000000, 32'h40000000, 32'h40800000);
    req_valid = 4'b1111;
    repeat (5) step();
    drain(3);
    apply_reset();
    req_valid = 4'b0011;
    step();
    drain(LAT + 4);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      issue_en = ($urandom_range(7) != 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        logic [1:0] op;
        logic [31:0] a, b;
        op = ($urandom_range(15) == 0) ? 2'b11 : 2'($urandom_range(2));
        a  = rnd_fp();
        b  = rnd_fp();
        set_req(i, op, a, b, fp_ref(a, b, op));
        req_valid[i] = ($urandom_range(2) != 0);
      end
      step();
    end
    issue_en = 1'b1;
    drain(LAT + 4);
    check("final_queue_empty", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
